// File: rtl/spi_pkg.sv
// Shared constants for the SPI register-write controller: frame size,
// FSM state encoding and the peripheral's register map.
package spi_pkg;

   localparam int FRAME_BITS = 16;
   localparam int BIT_CNT_W  = 5;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_HI,
      SHIFT_LO,
      HOLD,
      GAP
   } spi_state_e;

   localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

endpackage

// File: rtl/spi_controller_if.sv
// Host request bus plus serial pins of the SPI controller.
// The master modport is the host side; the slave modport is the controller.
interface spi_controller_if;
   import spi_pkg::*;

   logic       start;
   logic       rw;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       nCS;
   logic       SCLK;
   logic       COPI;
   logic       busy;
   logic       done;

   modport master (
      output start, rw, addr, wdata,
      input  nCS, SCLK, COPI, busy, done
   );

   modport slave (
      input  start, rw, addr, wdata,
      output nCS, SCLK, COPI, busy, done
   );

endinterface

// File: rtl/spi_phase_timer.sv
// Free-running phase timer: a down-counter that reloads to CLK_DIV-1 and
// strobes tc_o once every CLK_DIV cycles; load_i holds it at the reload value.
module spi_phase_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic tc_o
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q - CNT_W'(1);
      if (load_i || (cnt_q == '0)) begin
         cnt_d = RELOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 frame transmitter: latches {rw, addr, wdata} and shifts it out
// MSB first with CLK_DIV-cycle half periods; every pin comes from a flop.
//
// state    | meaning
// IDLE     | nCS high, waiting for start
// SETUP    | nCS low, first bit on COPI, SCLK low
// SHIFT_HI | SCLK high, peripheral samples COPI
// SHIFT_LO | SCLK low, next bit presented
// HOLD     | SCLK low after last bit, COPI held
// GAP      | nCS high recovery time, still busy
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input logic              clk,
   input logic              rst,
   spi_controller_if.slave  bus
);

   if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_clk_div_check
      $error("spi_controller: CLK_DIV must be within 3..255");
   end

   spi_state_e              state_q, state_d;
   logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
   logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic ncs_q, ncs_d, sclk_q, sclk_d, copi_q, copi_d;
   logic busy_q, busy_d, done_q, done_d;
   logic tc;
   logic frame_active;

   spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (state_q == IDLE),
      .tc_o   (tc)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = SETUP;
               shreg_d   = {bus.rw, bus.addr, bus.wdata};
               bit_cnt_d = '0;
            end
         end
         SETUP, SHIFT_LO: begin
            if (tc) begin
               state_d   = SHIFT_HI;
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
         end
         SHIFT_HI: begin
            if (tc) begin
               if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS)) begin
                  state_d = HOLD;
               end else begin
                  state_d = SHIFT_LO;
                  shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
               end
            end
         end
         HOLD: begin
            if (tc) state_d = GAP;
         end
         GAP: begin
            if (tc) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pins are decoded from the next state so they can be registered.
      frame_active = (state_d inside {SETUP, SHIFT_HI, SHIFT_LO, HOLD});
      ncs_d  = ~frame_active;
      sclk_d = (state_d == SHIFT_HI);
      copi_d = frame_active ? shreg_d[FRAME_BITS-1] : 1'b0;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         ncs_q     <= 1'b1;
         sclk_q    <= 1'b0;
         copi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         ncs_q     <= ncs_d;
         sclk_q    <= sclk_d;
         copi_q    <= copi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.nCS  = ncs_q;
   assign bus.SCLK = sclk_q;
   assign bus.COPI = copi_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
